// File: rtl/projectile_scheduler_pkg.sv
// Shared types and screen constants for the projectile scheduler slice.
package projectile_scheduler_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SOF,
        S_TICK,
        S_ARB,
        S_LAUNCH
    } sched_state_t;

    localparam int SCREEN_H = 480;
    localparam int COORD_W  = 11;

endpackage

// File: rtl/projectile_scheduler_if.sv
// Fire-request / launch bundle between requesters, scheduler and slot movers.
interface projectile_scheduler_if
    import projectile_scheduler_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int NUM_REQ   = 3
);
    logic                       startOfFrame;
    logic [NUM_REQ-1:0]         fire_req;
    logic [NUM_REQ*COORD_W-1:0] req_x;
    logic [NUM_REQ*COORD_W-1:0] req_y;
    logic [NUM_SLOTS-1:0]       slot_done;
    logic [NUM_SLOTS-1:0]       launch;
    logic [COORD_W-1:0]         launch_x;
    logic [COORD_W-1:0]         launch_y;
    logic [NUM_REQ-1:0]         fire_ack;
    logic [NUM_SLOTS-1:0]       slot_busy;

    modport master (
        input  startOfFrame, fire_req, req_x, req_y, slot_done,
        output launch, launch_x, launch_y, fire_ack, slot_busy
    );

    modport slave (
        output startOfFrame, fire_req, req_x, req_y, slot_done,
        input  launch, launch_x, launch_y, fire_ack, slot_busy
    );

endinterface

// File: rtl/projectile_scheduler_rr_arbiter.sv
// Round-robin arbiter: first requester at or above ptr wins, else wraps to the lowest.
module projectile_scheduler_rr_arbiter #(
    parameter int N     = 3,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic             valid
);
    logic [N-1:0] hi_grant;
    logic [N-1:0] lo_grant;
    logic         hi_found;

    always_comb begin
        hi_grant = '0;
        lo_grant = '0;
        hi_found = 1'b0;
        valid    = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i] && (PTR_W'(i) >= ptr)) begin
                hi_grant    = '0;
                hi_grant[i] = 1'b1;
                hi_found    = 1'b1;
            end
            if (req[i]) begin
                lo_grant    = '0;
                lo_grant[i] = 1'b1;
                valid       = 1'b1;
            end
        end
        grant = hi_found ? hi_grant : lo_grant;
    end

endmodule

// File: rtl/projectile_scheduler.sv
// Projectile slot pool: latches fire requests, applies cooldown and player cap, grants one slot per frame.
module projectile_scheduler
    import projectile_scheduler_pkg::*;
#(
    parameter int NUM_SLOTS       = 4,
    parameter int NUM_REQ         = 3,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int PLAYER_MAX      = 1,
    parameter int PLAYER_YOFF     = 33,
    parameter int ALIEN_YOFF      = 16
) (
    input logic                    clk,
    input logic                    resetN,
    projectile_scheduler_if.master bus
);
    localparam int REQ_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CNT_W  = 8;
    localparam logic [7:0]                CD_INIT = 8'(COOLDOWN_FRAMES);
    localparam logic [CNT_W-1:0]          PMAX    = CNT_W'(PLAYER_MAX);
    localparam logic signed [COORD_W:0]   P_OFF   = (COORD_W + 1)'(PLAYER_YOFF);
    localparam logic signed [COORD_W:0]   A_OFF   = (COORD_W + 1)'(ALIEN_YOFF);
    localparam logic signed [COORD_W:0]   Y_MAX   = (COORD_W + 1)'(SCREEN_H - 1);

    function automatic logic [COORD_W-1:0] sat_y(input logic signed [COORD_W:0] v);
        if (v[COORD_W]) return '0;
        if (v > Y_MAX) return Y_MAX[COORD_W-1:0];
        return v[COORD_W-1:0];
    endfunction

    sched_state_t         state, state_nxt;
    logic [NUM_REQ-1:0]   pending;
    logic [NUM_SLOTS-1:0] busy;
    logic [REQ_W-1:0]     owner [NUM_SLOTS];
    logic [7:0]           cooldown [NUM_REQ];
    logic [REQ_W-1:0]     rr_ptr;

    logic [NUM_REQ-1:0]        alien_req, alien_grant;
    logic                      alien_vld, free_any, player_elig, win_vld;
    logic [REQ_W-1:0]          alien_idx, win_idx;
    logic [SLOT_W-1:0]         free_slot;
    logic [CNT_W-1:0]          player_cnt;
    logic [COORD_W-1:0]        sel_x, sel_y;
    logic signed [COORD_W:0]   y_ext, y_off;

    logic [REQ_W-1:0]   win_req_p1;
    logic [SLOT_W-1:0]  win_slot_p1;
    logic [COORD_W-1:0] spawn_x_p1, spawn_y_p1;
    logic               vld_p1;

    assign alien_req = {pending[NUM_REQ-1:1], 1'b0};

    projectile_scheduler_rr_arbiter #(.N(NUM_REQ), .PTR_W(REQ_W)) u_rr (
        .req   (alien_req),
        .ptr   (rr_ptr),
        .grant (alien_grant),
        .valid (alien_vld)
    );

    // Stage p0: winner, free slot and spawn coordinates from current pending/busy
    always_comb begin
        free_any   = 1'b0;
        free_slot  = '0;
        player_cnt = '0;
        alien_idx  = '0;
        sel_x      = '0;
        sel_y      = '0;
        for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
            if (!busy[s]) begin
                free_any  = 1'b1;
                free_slot = SLOT_W'(s);
            end
        end
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (busy[s] && (owner[s] == '0)) player_cnt = player_cnt + CNT_W'(1);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (alien_grant[i]) alien_idx = REQ_W'(i);
        end
        player_elig = pending[0] && (player_cnt < PMAX);
        win_vld     = free_any && (player_elig || alien_vld);
        win_idx     = player_elig ? '0 : alien_idx;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == REQ_W'(i)) begin
                sel_x = bus.req_x[i*COORD_W +: COORD_W];
                sel_y = bus.req_y[i*COORD_W +: COORD_W];
            end
        end
        y_ext = signed'({1'b0, sel_y});
        y_off = (win_idx == '0) ? (y_ext - P_OFF) : (y_ext + A_OFF);
    end

    always_comb begin
        state_nxt    = state;
        bus.launch   = '0;
        bus.fire_ack = '0;
        bus.launch_x = '0;
        bus.launch_y = '0;
        case (state)
            S_IDLE, S_WAIT_SOF: if (bus.startOfFrame) state_nxt = S_TICK;
            S_TICK:             state_nxt = S_ARB;
            S_ARB:              state_nxt = win_vld ? S_LAUNCH : S_WAIT_SOF;
            S_LAUNCH:           state_nxt = S_WAIT_SOF;
            default:            state_nxt = S_IDLE;
        endcase
        if (vld_p1) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                if (win_slot_p1 == SLOT_W'(s)) bus.launch[s] = 1'b1;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (win_req_p1 == REQ_W'(i)) bus.fire_ack[i] = 1'b1;
            end
            bus.launch_x = spawn_x_p1;
            bus.launch_y = spawn_y_p1;
        end
    end

    assign vld_p1        = (state == S_LAUNCH);
    assign bus.slot_busy = busy;

    // Stage p1: ARB results held for the single LAUNCH cycle
    always_ff @(posedge clk) begin
        if (state == S_ARB) begin
            win_req_p1  <= win_idx;
            win_slot_p1 <= free_slot;
            spawn_x_p1  <= sel_x;
            spawn_y_p1  <= sat_y(y_off);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state   <= S_IDLE;
            pending <= '0;
            busy    <= '0;
            rr_ptr  <= REQ_W'(1);
            for (int s = 0; s < NUM_SLOTS; s++) owner[s] <= '0;
            for (int i = 0; i < NUM_REQ; i++) cooldown[i] <= '0;
        end else begin
            state <= state_nxt;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (vld_p1 && (win_req_p1 == REQ_W'(i))) begin
                    pending[i]  <= 1'b0;
                    cooldown[i] <= CD_INIT;
                end else begin
                    if ((state == S_TICK) && (cooldown[i] != 8'd0)) cooldown[i] <= cooldown[i] - 8'd1;
                    if (bus.fire_req[i] && (cooldown[i] == 8'd0)) pending[i] <= 1'b1;
                end
            end
            for (int s = 0; s < NUM_SLOTS; s++) begin
                if (vld_p1 && (win_slot_p1 == SLOT_W'(s))) begin
                    busy[s]  <= 1'b1;
                    owner[s] <= win_req_p1;
                end else if (bus.slot_done[s]) begin
                    busy[s] <= 1'b0;
                end
            end
            // rr only advances on alien grants so the player never perturbs alien fairness
            if (vld_p1 && (win_req_p1 != '0)) begin
                rr_ptr <= (win_req_p1 == REQ_W'(NUM_REQ - 1)) ? REQ_W'(1) : (win_req_p1 + REQ_W'(1));
            end
        end
    end

endmodule
